// File: rtl/nn_layer_sequencer_pkg.sv
// nn_pkg: shared types and default sizes for the inference sequencer.
//   state_t - sequencer FSM states
//   tag_t   - write-address tag that travels alongside the sigmoid operand
package nn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANES  = 10;
  localparam int DEF_N_ROWS = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    ACT,
    DRAIN,
    W2,
    DONE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [3:0] col;
  } tag_t;

endpackage

// File: rtl/nn_layer_sequencer_tag_delay.sv
// nn_tag_delay: DEPTH-stage shift register of write tags. It matches the
// sigmoid latency so each tag leaves in the same cycle as its result.
//   clk, reset - clock, synchronous active-high reset
//   flush      - synchronous clear of every stage (run cancelled)
//   tag_in     - tag pushed this cycle
//   tag_out    - tag pushed DEPTH cycles ago
module nn_tag_delay
  import nn_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: per input row, fetch a Layer1Calc column, stream its
// lanes through the sigmoid unit and write the results to gSRAM at
// (row, lane); afterwards sweep the w2SRAM addresses once.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   start, abort           - run start pulse, cancel level (abort wins)
//   busy, done             - not-IDLE flag, run-complete pulse
//   in_addr                - inputSRAM address (current row)
//   l1_start, l1_done,
//   l1_column              - Layer1Calc handshake and result column
//   sig_in, sig_out        - sigmoid operand / result (SIG_LAT cycles later)
//   g_we, g_row, g_col,
//   g_wdata                - gSRAM write port
//   w2_addr, w2_valid      - w2SRAM address and its data-valid strobe
//   perf_cycles            - busy-cycle counter
// Build option: define NNSEQ_PERF_EN to build the saturating busy-cycle
// counter; otherwise perf_cycles is tied to 0.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LANES   = DEF_LANES,
  parameter int N_ROWS  = DEF_N_ROWS,
  parameter int SIG_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              in_addr,
  output logic                    l1_start,
  input  logic                    l1_done,
  input  logic [LANES*DATA_W-1:0] l1_column,
  output logic [DATA_W-1:0]       sig_in,
  input  logic [DATA_W-1:0]       sig_out,
  output logic                    g_we,
  output logic [3:0]              g_row,
  output logic [3:0]              g_col,
  output logic [DATA_W-1:0]       g_wdata,
  output logic [3:0]              w2_addr,
  output logic                    w2_valid,
  output logic [31:0]             perf_cycles
);

  localparam int DCW = (SIG_LAT > 1) ? $clog2(SIG_LAT) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(SIG_LAT - 1);
  localparam logic [3:0]     ROW_LAST   = 4'(N_ROWS - 1);
  localparam logic [3:0]     LANE_LAST  = 4'(LANES - 1);
  localparam logic [4:0]     W2_END     = 5'(N_ROWS);

  state_t                        state, state_nxt;
  logic [3:0]                    row, row_nxt;
  logic [3:0]                    lane, lane_nxt;
  logic [DCW-1:0]                drain_cnt, drain_nxt;
  logic [4:0]                    w2_cnt, w2_nxt;
  logic [LANES-1:0][DATA_W-1:0]  col_reg;
  logic                          col_ld, push, w2_issue;
  tag_t                          tag_in, tag_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      lane      <= '0;
      drain_cnt <= '0;
      w2_cnt    <= '0;
      col_reg   <= '0;
      w2_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      lane      <= lane_nxt;
      drain_cnt <= drain_nxt;
      w2_cnt    <= w2_nxt;
      if (col_ld) col_reg <= l1_column;
      w2_valid  <= w2_issue && !abort;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    lane_nxt  = lane;
    drain_nxt = drain_cnt;
    w2_nxt    = w2_cnt;
    col_ld    = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = WAIT;
      WAIT:  if (l1_done) begin
               col_ld    = 1'b1;
               lane_nxt  = '0;
               state_nxt = ACT;
             end
      ACT: begin
        push     = 1'b1;
        lane_nxt = lane + 4'd1;
        if (lane == LANE_LAST) begin
          drain_nxt = '0;
          state_nxt = DRAIN;
        end
      end
      // Wait out the sigmoid latency so the row's last write lands
      // before the next row (or W2) begins.
      DRAIN: begin
        drain_nxt = drain_cnt + 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          drain_nxt = '0;
          if (row == ROW_LAST) begin
            row_nxt   = '0;
            w2_nxt    = '0;
            state_nxt = W2;
          end else begin
            row_nxt   = row + 4'd1;
            state_nxt = LOAD;
          end
        end
      end
      // N_ROWS issue cycles plus one tail cycle carrying the last w2_valid.
      W2: begin
        w2_nxt = w2_cnt + 5'd1;
        if (w2_cnt == W2_END) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      row_nxt   = '0;
      lane_nxt  = '0;
      drain_nxt = '0;
      w2_nxt    = '0;
      col_ld    = 1'b0;
      push      = 1'b0;
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign l1_start = (state == LOAD);
  assign in_addr  = row;
  assign sig_in   = (state == ACT) ? col_reg[lane] : '0;
  assign w2_issue = (state == W2) && (w2_cnt < W2_END);
  assign w2_addr  = w2_issue ? w2_cnt[3:0] : '0;

  assign tag_in = push ? '{valid: 1'b1, row: row, col: lane} : '0;

  nn_tag_delay #(.DEPTH(SIG_LAT)) u_tag_delay (
    .clk     (clk),
    .reset   (reset),
    .flush   (abort),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign g_we    = tag_out.valid;
  assign g_row   = tag_out.row;
  assign g_col   = tag_out.col;
  assign g_wdata = tag_out.valid ? sig_out : '0;

`ifdef NNSEQ_PERF_EN
  logic start_ok;
  assign start_ok = (state == IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (reset || start_ok)                     perf_cycles <= '0;
    else if (busy && perf_cycles != '1)        perf_cycles <= perf_cycles + 32'd1;
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: behavioural Layer1Calc and sigmoid models,
// a gSRAM image checked against expected activations, cycle accounting.
module tb_nn_layer_sequencer;
  localparam int DW = 16, LN = 10, NR = 16, SL = 1, SL3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] sigf(input logic [DW-1:0] x);
    return DW'((x ^ 16'h5A5A) + 16'd17);
  endfunction

  // ---------------- main DUT ----------------
  logic reset, start, abort;
  logic busy, done, l1_start, l1_done, g_we, w2_valid;
  logic [3:0] in_addr, g_row, g_col, w2_addr;
  logic [LN*DW-1:0] l1_column;
  logic [DW-1:0] sig_in, sig_out, g_wdata;
  logic [31:0] perf;

  nn_layer_sequencer #(.DATA_W(DW), .LANES(LN), .N_ROWS(NR), .SIG_LAT(SL)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .in_addr(in_addr), .l1_start(l1_start), .l1_done(l1_done), .l1_column(l1_column),
    .sig_in(sig_in), .sig_out(sig_out), .g_we(g_we), .g_row(g_row), .g_col(g_col),
    .g_wdata(g_wdata), .w2_addr(w2_addr), .w2_valid(w2_valid), .perf_cycles(perf));

  // ---------------- single-row DUT, SIG_LAT=3 ----------------
  logic start3, abort3 = 1'b0;
  logic busy3, done3, l1_start3, l1_done3 = 1'b0, g_we3, w2_valid3;
  logic [3:0] in_addr3, g_row3, g_col3, w2_addr3;
  logic [LN*DW-1:0] l1_column3;
  logic [DW-1:0] sig_in3, sig_out3, g_wdata3;
  logic [31:0] perf3;

  nn_layer_sequencer #(.DATA_W(DW), .LANES(LN), .N_ROWS(1), .SIG_LAT(SL3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .busy(busy3), .done(done3),
    .in_addr(in_addr3), .l1_start(l1_start3), .l1_done(l1_done3), .l1_column(l1_column3),
    .sig_in(sig_in3), .sig_out(sig_out3), .g_we(g_we3), .g_row(g_row3), .g_col(g_col3),
    .g_wdata(g_wdata3), .w2_addr(w2_addr3), .w2_valid(w2_valid3), .perf_cycles(perf3));

  logic [DW-1:0] col_data [NR][LN];
  logic [DW-1:0] col3_data [LN];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Layer1Calc model: l1_done arrives lat cycles after l1_start.
  int l1_cnt = 0, lat_sum = 0, lat_fix = 3, lat_n;
  bit lat_rand = 0;
  logic l1_done_r = 1'b0, spur = 1'b0;
  assign l1_done = l1_done_r | spur;
  always @(posedge clk) begin
    l1_done_r <= 1'b0;
    if (reset || abort) l1_cnt <= 0;
    else if (l1_cnt > 0) begin
      l1_cnt <= l1_cnt - 1;
      if (l1_cnt == 1) begin
        l1_done_r <= 1'b1;
        for (int k = 0; k < LN; k++) l1_column[k*DW +: DW] <= col_data[in_addr][k];
      end
    end else if (l1_start) begin
      lat_n = lat_rand ? int'($urandom_range(2, 6)) : lat_fix;
      l1_cnt  <= lat_n - 1;
      lat_sum <= lat_sum + lat_n;
    end
  end

  int c3 = 0;
  always @(posedge clk) begin
    l1_done3 <= 1'b0;
    if (reset) c3 <= 0;
    else if (c3 > 0) begin
      c3 <= c3 - 1;
      if (c3 == 1) begin
        l1_done3 <= 1'b1;
        for (int k = 0; k < LN; k++) l1_column3[k*DW +: DW] <= col3_data[k];
      end
    end else if (l1_start3) c3 <= 2;
  end

  // Sigmoid models: fixed-latency pipelines of sigf().
  logic [DW-1:0] sp [SL];
  logic [DW-1:0] sp3 [SL3];
  always @(posedge clk) begin
    sp[0] <= sig_in;
    for (int i = 1; i < SL; i++) sp[i] <= sp[i-1];
    sp3[0] <= sig_in3;
    for (int i = 1; i < SL3; i++) sp3[i] <= sp3[i-1];
  end
  assign sig_out  = sigf(sp[SL-1]);
  assign sig_out3 = sigf(sp3[SL3-1]);

  // gSRAM image and event counters for the main DUT.
  bit clr = 0;
  int wr_cnt, done_cnt, busy_cnt, w2v_cnt, w2_err, w2_last, bad_addr;
  int wcnt [NR][LN];
  logic [DW-1:0] gmem [NR][LN];
  logic [3:0] prev_w2 = '0;
  always @(negedge clk) begin
    if (clr) begin
      wr_cnt = 0; done_cnt = 0; busy_cnt = 0; w2v_cnt = 0; w2_err = 0; w2_last = 0; bad_addr = 0;
      for (int r = 0; r < NR; r++) for (int k = 0; k < LN; k++) wcnt[r][k] = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (g_we) begin
        wr_cnt++;
        if (g_col < 4'(LN)) begin
          wcnt[g_row][g_col]++;
          gmem[g_row][g_col] = g_wdata;
        end else bad_addr++;
      end
      if (w2_valid) begin
        if (prev_w2 != 4'(w2v_cnt)) w2_err++;
        if (w2v_cnt > 0 && cyc != w2_last + 1) w2_err++;
        w2_last = cyc;
        w2v_cnt++;
      end
    end
    prev_w2 = w2_addr;
  end

  int act3 = -1, we3_first = -1, idx3 = 0, col_err3 = 0, dat_err3 = 0, done3_cnt = 0, w2v3_cnt = 0;
  always @(negedge clk) begin
    if (l1_done3 && act3 < 0) act3 = cyc + 1;
    if (g_we3) begin
      if (we3_first < 0) we3_first = cyc;
      if (g_col3 != 4'(idx3) || g_row3 != 4'd0) col_err3++;
      if (idx3 < LN && g_wdata3 !== sigf(col3_data[idx3])) dat_err3++;
      idx3++;
    end
    if (done3) done3_cnt++;
    if (w2_valid3) w2v3_cnt++;
  end

  task automatic do_clr();
    @(posedge clk); #1 clr = 1;
    @(negedge clk); #1 clr = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input string p, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < budget);
    chk({p, ".done_seen"}, done, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Expected busy cycles: per row 2 + (lat-1) + LANES + SIG_LAT, then
  // W2 (N_ROWS issue + 1 tail) and one DONE cycle.
  function automatic int exp_busy(input int lats);
    return NR * (1 + LN + SL) + lats + (NR + 1) + 1;
  endfunction

  task automatic check_run(input string p, input int lats);
    int bad = 0, baddata = 0;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < LN; k++)
        if (wcnt[r][k] != 1) bad++;
        else if (gmem[r][k] !== sigf(col_data[r][k])) baddata++;
    chk({p, ".writes"}, wr_cnt, NR * LN);
    chk({p, ".cells_not_once"}, bad, 0);
    chk({p, ".bad_col_addr"}, bad_addr, 0);
    chk({p, ".data"}, baddata, 0);
    chk({p, ".done_pulses"}, done_cnt, 1);
    chk({p, ".busy_after"}, busy, 0);
    chk({p, ".busy_cycles"}, busy_cnt, exp_busy(lats));
    chk({p, ".w2_count"}, w2v_cnt, NR);
    chk({p, ".w2_order"}, w2_err, 0);
`ifdef NNSEQ_PERF_EN
    chk({p, ".perf"}, perf, busy_cnt);
`else
    chk({p, ".perf"}, perf, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lb, n, wsnap, bad;
    reset = 1; start = 0; abort = 0; start3 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);      chk("rst.done", done, 0);
    chk("rst.l1_start", l1_start, 0); chk("rst.g_we", g_we, 0);
    chk("rst.w2_valid", w2_valid, 0); chk("rst.in_addr", in_addr, 0);
    chk("rst.sig_in", sig_in, 0);  chk("rst.perf", perf, 0);
    chk("rst.busy3", busy3, 0);
    reset = 0;

    // Run 1: lane k of row r = r*16+k, Layer1 latency 3.
    for (int r = 0; r < NR; r++) for (int k = 0; k < LN; k++) col_data[r][k] = DW'(r * 16 + k);
    lat_rand = 0; lat_fix = 3;
    do_clr(); lb = lat_sum;
    pulse_start();
    wait_done("run1", 3000);
    check_run("run1", lat_sum - lb);

    // Run 2: random data and latency; start pokes during WAIT and W2.
    for (int r = 0; r < NR; r++) for (int k = 0; k < LN; k++) col_data[r][k] = DW'($urandom);
    lat_rand = 1;
    do_clr(); lb = lat_sum;
    pulse_start();
    n = 0; do begin @(negedge clk); n++; end while (!l1_start && n < 50);
    chk("run2.l1_start_seen", l1_start, 1);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    n = 0; do begin @(negedge clk); n++; end while (!w2_valid && n < 3000);
    chk("run2.w2_seen", w2_valid, 1);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_done("run2", 100);
    check_run("run2", lat_sum - lb);

    // Idle: stray l1_done, then start+abort together.
    do_clr();
    @(posedge clk); #1 spur = 1;
    @(posedge clk); #1 spur = 0;
    repeat (2) @(posedge clk); #1;
    chk("idle.l1_done_busy", busy, 0);
    @(posedge clk); #1 start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    chk("idle.start_abort_busy", busy, 0);
    repeat (3) @(posedge clk); #1;
    chk("idle.writes", wr_cnt, 0);
    chk("idle.busy_cycles", busy_cnt, 0);

    // Abort in ACT of row 5, lane 4.
    for (int r = 0; r < NR; r++) for (int k = 0; k < LN; k++) col_data[r][k] = DW'($urandom);
    lat_rand = 0; lat_fix = 3;
    do_clr();
    pulse_start();
    n = 0; do begin @(negedge clk); n++; end while (!(l1_done && in_addr == 4'd5) && n < 3000);
    chk("abort.row5_reached", in_addr, 5);
    repeat (5) @(posedge clk);
    #1 abort = 1;
    chk("abort.lane4_sig_in", sig_in, col_data[5][4]);
    @(posedge clk); #1 abort = 0;
    chk("abort.busy_next", busy, 0);
    chk("abort.in_addr", in_addr, 0);
    repeat (30) @(posedge clk); #1;
    bad = 0;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < LN; k++)
        if (wcnt[r][k] != ((r < 5 || (r == 5 && k < 4)) ? 1 : 0)) bad++;
    chk("abort.writes", wr_cnt, 5 * LN + 4);
    chk("abort.cells", bad, 0);
    chk("abort.done", done_cnt, 0);
    do_clr(); lb = lat_sum;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("restart.in_addr", in_addr, 0);
    chk("restart.l1_start", l1_start, 1);
    wait_done("restart", 3000);
    check_run("restart", lat_sum - lb);

    // Reset mid-run.
    do_clr();
    pulse_start();
    repeat (40) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    wsnap = wr_cnt;
    chk("mrst.busy", busy, 0);     chk("mrst.g_we", g_we, 0);
    chk("mrst.in_addr", in_addr, 0); chk("mrst.sig_in", sig_in, 0);
    chk("mrst.perf", perf, 0);
    reset = 0;
    repeat (20) @(posedge clk); #1;
    chk("mrst.busy_after", busy, 0);
    chk("mrst.no_writes", wr_cnt, wsnap);
    chk("mrst.no_done", done_cnt, 0);

    // Single row, SIG_LAT=3.
    for (int k = 0; k < LN; k++) col3_data[k] = DW'($urandom);
    @(posedge clk); #1 start3 = 1;
    @(posedge clk); #1 start3 = 0;
    n = 0; do begin @(negedge clk); n++; end while (!done3 && n < 200);
    repeat (3) @(posedge clk); #1;
    chk("sl3.first_we_lag", we3_first - act3, 3);
    chk("sl3.writes", idx3, LN);
    chk("sl3.col_order", col_err3, 0);
    chk("sl3.data", dat_err3, 0);
    chk("sl3.done", done3_cnt, 1);
    chk("sl3.w2_valid", w2v3_cnt, 1);
    chk("sl3.busy_after", busy3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
